mem_block_reader: RTL



---
 rtl/mem_pkg.sv | 9 +
 rtl/mem_rd_skid.sv | 34 +++
 rtl/mem_block_reader.sv | 97 +++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared read-engine FSM states, default memory geometry (8b x 16) and address-wrap helper
package mem_pkg;
  localparam int MEM_DATA_W = 8;
  localparam int MEM_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} rd_state_e;
  function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned depth);
    return (a + 1) % depth;
  endfunction
endpackage

// File: rtl/mem_rd_skid.sv
// mem_rd_skid: 2-entry FIFO between memory read data and the output stream (clk, rst, push/din in, pop in, dout/valid/occ out)
module mem_rd_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);
  logic [W-1:0] buf_q [2];
  logic wr_q, rd_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) begin
        buf_q[wr_q] <= din;
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
  assign valid = occ != 2'd0;
  assign dout = buf_q[rd_q];
endmodule

// File: rtl/mem_block_reader.sv
// mem_block_reader: wrap-around burst reader from sync-read memory to valid/ready stream (start/base_addr/count in, busy/done out, mem_rd_en/mem_addr/mem_rdata, out_valid/out_data/out_last/out_ready, out_par when MEM_BLOCK_READER_PARITY_EN)
module mem_block_reader
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int DEPTH = MEM_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [AW:0]       count,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
`ifdef MEM_BLOCK_READER_PARITY_EN
  output logic              out_par,
`endif
  input  logic              out_ready
);
`ifdef MEM_BLOCK_READER_PARITY_EN
  localparam int BW = DATA_W + 1;
`else
  localparam int BW = DATA_W;
`endif
  rd_state_e state, nxt;
  logic [AW-1:0] addr_q;
  logic [AW:0] remain_q, beats_q;
  logic inflight_q, pop;
  logic [1:0] occ;
  logic [2:0] load;
  logic [BW-1:0] din, head;
  assign pop = out_valid && out_ready;
  // words held or returning after this edge; issuing keeps it at most 2
  assign load = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? (start ? (count != '0 ? READ : FIN) : IDLE)
        : state == READ ? (mem_rd_en && remain_q == (AW+1)'(1) ? DRAIN : READ)
        : state == DRAIN ? (pop && out_last ? FIN : DRAIN)
        : IDLE;
  end
  always_comb begin
    busy = state == READ || state == DRAIN;
    done = state == FIN;
    mem_rd_en = state == READ && remain_q != '0 && load < 3'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      remain_q <= '0;
      beats_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= mem_rd_en;
      if (state == IDLE && start) begin
        addr_q <= base_addr;
        remain_q <= count;
        beats_q <= count;
      end else begin
        if (mem_rd_en) begin
          addr_q <= AW'(wrap_inc(int'(addr_q), DEPTH));
          remain_q <= remain_q - (AW+1)'(1);
        end
        if (pop) beats_q <= beats_q - (AW+1)'(1);
      end
    end
  end
  assign mem_addr = addr_q;
  assign out_last = out_valid && beats_q == (AW+1)'(1);
  assign out_data = head[DATA_W-1:0];
`ifdef MEM_BLOCK_READER_PARITY_EN
  assign din = {^mem_rdata, mem_rdata};
  assign out_par = head[DATA_W];
`else
  assign din = mem_rdata;
`endif
  mem_rd_skid #(.W(BW)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(inflight_q),
    .pop(pop),
    .din(din),
    .dout(head),
    .valid(out_valid),
    .occ(occ)
  );
endmodule
